gowin_tx_bridge: RTL and testbench
==================================

// Module: gowin_tx_bridge
// PURPOSE
//  TX-side stage feeding the Gowin PCIe hard-IP transmit stream. Accepts TLP beats on the
//  RIFFA "TX Classic" interface (start/end flags + dword offsets), checks framing, converts
//  them to Gowin SOP/EOP/VALID/EMPTY/dword-enable form, and decouples both sides with a
//  2-entry skid buffer so TX_TLP_READY is registered.
// PARAMETERS
//  C_PCI_DATA_WIDTH  256  datapath width; only 256 supported (8 dwords/beat)
//  C_PKT_CNT_W       16   width of forwarded-packet counter
// PORTS
//  CLK                  in   1    clock; single clock domain
//  RST_IN               in   1    reset, asynchronous, active-high
//  TX_TLP               in   256  beat data, dword 0 = bits [31:0]
//  TX_TLP_VALID         in   1    beat valid
//  TX_TLP_START_FLAG    in   1    first beat of TLP
//  TX_TLP_START_OFFSET  in   3    first valid dword of first beat; must be 0
//  TX_TLP_END_FLAG      in   1    last beat of TLP
//  TX_TLP_END_OFFSET    in   3    index of last valid dword in last beat
//  TX_TLP_READY         out  1    beat accepted when VALID&&READY
//  TX_ST_DATA           out  256  beat data to hard IP
//  TX_ST_VALID          out  1    output beat valid
//  TX_ST_READY          in   1    hard IP accepts when VALID&&READY (ready latency 0)
//  TX_ST_SOP            out  1    start of packet
//  TX_ST_EOP            out  1    end of packet
//  TX_ST_EMPTY          out  1    on EOP beat: dwords 4..7 unused (END_OFFSET<4); else 0
//  TX_ST_DWEN           out  8    dword-enable mask; 8'hFF except EOP beat
//  TX_FRAME_ERR         out  1    sticky framing-error flag
//  TX_PKT_COUNT         out  C_PKT_CNT_W  count of EOP beats delivered to hard IP
// BEHAVIOUR
//  Reset (async assert, sync deassert is caller's job): TX_TLP_READY=0 for the reset
//   cycle then 1; TX_ST_VALID/SOP/EOP/EMPTY=0, TX_ST_DWEN=0, TX_ST_DATA=0, ERR=0, COUNT=0,
//   FSM=IDLE, buffer empty. Reset mid-packet discards buffered beats; no EOP is emitted.
//  Skid buffer: 2 entries {data,sop,eop,empty,dwen}. TX_TLP_READY = registered !full
//   (i.e. occupancy<2 after this cycle's updates). Head drives TX_ST_* directly from regs.
//   Latency: accepted beat appears on TX_ST_VALID next cycle if buffer was empty.
//   Simultaneous push and pop: occupancy unchanged, order preserved. Full: READY=0,
//   head held stable while TX_ST_READY=0 (data/flags must not change while VALID&&!READY).
//  Framing FSM (advances only on accepted input beats):
//   IDLE: START&&END -> push single-beat pkt, stay IDLE. START&&!END -> push, IN_PKT.
//         !START -> beat discarded (not pushed), ERR<=1.
//   IN_PKT: END -> push with EOP, IDLE. !END -> push, stay.
//         START seen -> pushed with SOP forced 0, ERR<=1 (output framing stays legal).
//   START with START_OFFSET!=0: beat still forwarded, ERR<=1.
//  Conversion: SOP=START (per FSM), EOP=END; on EOP beat DWEN = (2<<END_OFFSET)-1
//   computed in 9 bits, truncated to 8 (offset 7 -> 8'hFF, 0 -> 8'h01);
//   EMPTY = EOP && END_OFFSET<4. Non-EOP beats: DWEN=8'hFF, EMPTY=0.
//  TX_PKT_COUNT increments when an EOP beat pops (TX_ST_VALID&&TX_ST_READY&&TX_ST_EOP);
//   wraps modulo 2^C_PKT_CNT_W. TX_FRAME_ERR clears only on reset.
// STRUCTURE
//  Shared package riffa_gowin_pkg: localparams DW_PER_BEAT=8, OFFSET_W=3; typedef struct
//   packed tx_beat_t {data,sop,eop,empty,dwen}; enum tx_state_e {TX_IDLE,TX_IN_PKT}.
//  One sub-module: gowin_skid_buf #(type T) – generic 2-entry valid/ready skid buffer;
//   top holds FSM, flag conversion, counter, error flag.
// TESTING
//  1 single-beat TLP, START=END=1, END_OFFSET=2, ST_READY=1 -> next cycle VALID,SOP,EOP=1,
//    DWEN=8'h07, EMPTY=1, COUNT=1, ERR=0.
//  2 3-beat TLP, END_OFFSET=7 -> SOP on beat0 only, EOP on beat2, DWEN FF/FF/FF, EMPTY=0.
//  3 ST_READY=0 for 5 cycles during stream -> TX_TLP_READY drops after 2 beats buffered,
//    head data stable, no loss/duplication; order intact after release.
//  4 random ST_READY (50%) with back-to-back TLPs, 1000 pkts -> scoreboard matches, COUNT=1000.
//  5 beat with START=0 in IDLE -> not forwarded, ERR=1; following legal TLP passes intact.
//  6 RST_IN asserted mid-packet with 2 beats buffered -> outputs zero same cycle, COUNT=0,
//    post-reset TLP forwarded with correct SOP.

Source files
------------

// File: rtl/gowin_tx_bridge_pkg.sv
// Shared types for the RIFFA-to-Gowin TX path: beat record, framing states
// and the end-of-packet dword-enable helper.
package riffa_gowin_pkg;

    localparam int DW_PER_BEAT = 8;
    localparam int OFFSET_W    = 3;
    localparam int BEAT_DATA_W = 32 * DW_PER_BEAT;

    typedef struct packed {
        logic [BEAT_DATA_W-1:0] data;
        logic                   sop;
        logic                   eop;
        logic                   empty;
        logic [DW_PER_BEAT-1:0] dwen;
    } tx_beat_t;

    typedef enum logic {
        TX_IDLE   = 1'b0,
        TX_IN_PKT = 1'b1
    } tx_state_e;

    // Offset 7 overflows into bit 8, which is dropped to give a full mask.
    function automatic logic [DW_PER_BEAT-1:0] eop_dwen(input logic [OFFSET_W-1:0] end_off);
        logic [DW_PER_BEAT:0] mask;
        mask = ((DW_PER_BEAT+1)'(2) << end_off) - (DW_PER_BEAT+1)'(1);
        return mask[DW_PER_BEAT-1:0];
    endfunction

endpackage

// File: rtl/gowin_skid_buf.sv
// Generic two-entry valid/ready skid buffer; the head entry drives the output
// straight from flops and in_ready is registered.
module gowin_skid_buf #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  T     in_data,
    output logic in_ready,
    output logic out_valid,
    output T     out_data,
    input  logic out_ready
);

    logic [1:0] cnt_q, cnt_d;
    logic       rdy_q, rdy_d;
    T           head_q, head_d;
    T           tail_q, tail_d;
    logic       push, pop;

    assign push = in_valid && rdy_q;
    assign pop  = (cnt_q != 2'd0) && out_ready;

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = in_data;
                else               tail_d = in_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new beat lands behind whatever remains.
                if (cnt_q == 2'd1) begin
                    head_d = in_data;
                end else begin
                    head_d = tail_q;
                    tail_d = in_data;
                end
            end
            default: ;
        endcase
        rdy_d = (cnt_d < 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            rdy_q  <= 1'b0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            rdy_q  <= rdy_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = head_q;

endmodule

// File: rtl/gowin_tx_bridge.sv
// RIFFA TX Classic to Gowin PCIe TX stream: framing check, flag/dword-enable
// conversion, 2-deep output decoupling, packet counter and sticky error flag.
module gowin_tx_bridge
    import riffa_gowin_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 256,
    parameter int C_PKT_CNT_W      = 16
) (
    input  logic                        CLK,
    input  logic                        RST_IN,
    input  logic [C_PCI_DATA_WIDTH-1:0] TX_TLP,
    input  logic                        TX_TLP_VALID,
    input  logic                        TX_TLP_START_FLAG,
    input  logic [OFFSET_W-1:0]         TX_TLP_START_OFFSET,
    input  logic                        TX_TLP_END_FLAG,
    input  logic [OFFSET_W-1:0]         TX_TLP_END_OFFSET,
    output logic                        TX_TLP_READY,
    output logic [C_PCI_DATA_WIDTH-1:0] TX_ST_DATA,
    output logic                        TX_ST_VALID,
    input  logic                        TX_ST_READY,
    output logic                        TX_ST_SOP,
    output logic                        TX_ST_EOP,
    output logic                        TX_ST_EMPTY,
    output logic [DW_PER_BEAT-1:0]      TX_ST_DWEN,
    output logic                        TX_FRAME_ERR,
    output logic [C_PKT_CNT_W-1:0]      TX_PKT_COUNT
);

    tx_state_e              state_q, state_d;
    logic                   err_q, err_d;
    logic [C_PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    tx_beat_t beat_in, beat_out;
    logic     accept, push, tlp_ready, st_valid;

    assign accept = TX_TLP_VALID && tlp_ready;

    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        push          = 1'b0;
        beat_in       = '0;
        beat_in.data  = TX_TLP;
        beat_in.eop   = TX_TLP_END_FLAG;
        // Offsets 0..3 leave the upper half of the beat unused.
        beat_in.empty = TX_TLP_END_FLAG && !TX_TLP_END_OFFSET[OFFSET_W-1];
        beat_in.dwen  = TX_TLP_END_FLAG ? eop_dwen(TX_TLP_END_OFFSET) : '1;
        if (accept) begin
            case (state_q)
                TX_IDLE: begin
                    if (TX_TLP_START_FLAG) begin
                        push        = 1'b1;
                        beat_in.sop = 1'b1;
                        if (TX_TLP_START_OFFSET != '0) err_d = 1'b1;
                        if (!TX_TLP_END_FLAG)          state_d = TX_IN_PKT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                TX_IN_PKT: begin
                    // A stray START is forwarded as a continuation so the
                    // hard IP never sees a nested SOP.
                    push = 1'b1;
                    if (TX_TLP_START_FLAG) err_d = 1'b1;
                    if (TX_TLP_END_FLAG)   state_d = TX_IDLE;
                end
                default: state_d = TX_IDLE;
            endcase
        end
    end

    gowin_skid_buf #(.T(tx_beat_t)) u_skid (
        .clk       (CLK),
        .rst       (RST_IN),
        .in_valid  (push),
        .in_data   (beat_in),
        .in_ready  (tlp_ready),
        .out_valid (st_valid),
        .out_data  (beat_out),
        .out_ready (TX_ST_READY)
    );

    assign pkt_cnt_d = (st_valid && TX_ST_READY && beat_out.eop)
                     ? pkt_cnt_q + C_PKT_CNT_W'(1) : pkt_cnt_q;

    always_ff @(posedge CLK or posedge RST_IN) begin
        if (RST_IN) begin
            state_q   <= TX_IDLE;
            err_q     <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign TX_TLP_READY = tlp_ready;
    assign TX_ST_VALID  = st_valid;
    assign TX_ST_DATA   = beat_out.data;
    assign TX_ST_SOP    = beat_out.sop;
    assign TX_ST_EOP    = beat_out.eop;
    assign TX_ST_EMPTY  = beat_out.empty;
    assign TX_ST_DWEN   = beat_out.dwen;
    assign TX_FRAME_ERR = err_q;
    assign TX_PKT_COUNT = pkt_cnt_q;

endmodule

// File: tb/tb_gowin_tx_bridge.sv
// Bench for gowin_tx_bridge: directed vector table, backpressure and reset
// sequences, and a randomized packet stream checked by a queue model.
module tb_gowin_tx_bridge;

    logic         CLK = 1'b0;
    logic         RST_IN = 1'b1;
    logic [255:0] TX_TLP = '0;
    logic         TX_TLP_VALID = 1'b0;
    logic         TX_TLP_START_FLAG = 1'b0;
    logic [2:0]   TX_TLP_START_OFFSET = '0;
    logic         TX_TLP_END_FLAG = 1'b0;
    logic [2:0]   TX_TLP_END_OFFSET = '0;
    logic         TX_TLP_READY;
    logic [255:0] TX_ST_DATA;
    logic         TX_ST_VALID;
    logic         TX_ST_READY = 1'b0;
    logic         TX_ST_SOP, TX_ST_EOP, TX_ST_EMPTY;
    logic [7:0]   TX_ST_DWEN;
    logic         TX_FRAME_ERR;
    logic [15:0]  TX_PKT_COUNT;

    gowin_tx_bridge #(.C_PCI_DATA_WIDTH(256), .C_PKT_CNT_W(16)) dut (
        .CLK(CLK), .RST_IN(RST_IN), .TX_TLP(TX_TLP), .TX_TLP_VALID(TX_TLP_VALID),
        .TX_TLP_START_FLAG(TX_TLP_START_FLAG), .TX_TLP_START_OFFSET(TX_TLP_START_OFFSET),
        .TX_TLP_END_FLAG(TX_TLP_END_FLAG), .TX_TLP_END_OFFSET(TX_TLP_END_OFFSET),
        .TX_TLP_READY(TX_TLP_READY), .TX_ST_DATA(TX_ST_DATA), .TX_ST_VALID(TX_ST_VALID),
        .TX_ST_READY(TX_ST_READY), .TX_ST_SOP(TX_ST_SOP), .TX_ST_EOP(TX_ST_EOP),
        .TX_ST_EMPTY(TX_ST_EMPTY), .TX_ST_DWEN(TX_ST_DWEN), .TX_FRAME_ERR(TX_FRAME_ERR),
        .TX_PKT_COUNT(TX_PKT_COUNT)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [255:0] data;
        logic         sop;
        logic         eop;
        logic         empty;
        logic [7:0]   dwen;
    } exp_t;

    exp_t        exp_q[$];
    logic        m_inpkt = 1'b0;
    logic        m_err = 1'b0;
    logic [15:0] m_cnt = '0;
    logic        prev_rst = 1'b1;
    logic        prev_hold = 1'b0;
    exp_t        prev_head;
    bit          rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference: every forwarded beat is queued in order; the queue length is
    // the buffer occupancy the design must report through READY/VALID.
    always @(negedge CLK) begin
        exp_t e, h;
        bit   fwd;
        if (RST_IN) begin
            exp_q.delete();
            m_inpkt   = 1'b0;
            m_err     = 1'b0;
            m_cnt     = '0;
            prev_rst  = 1'b1;
            prev_hold = 1'b0;
        end else begin
            h = {TX_ST_DATA, TX_ST_SOP, TX_ST_EOP, TX_ST_EMPTY, TX_ST_DWEN};
            chk("mon_ready", TX_TLP_READY, !prev_rst && (exp_q.size() < 2));
            chk("mon_valid", TX_ST_VALID, exp_q.size() != 0);
            chk("mon_count", TX_PKT_COUNT, m_cnt);
            chk("mon_err", TX_FRAME_ERR, m_err);
            if (prev_hold && TX_ST_VALID) chk("mon_hold_stable", h, prev_head);
            if (TX_ST_VALID && TX_ST_READY && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("mon_beat", h, e);
                if (e.eop) m_cnt = m_cnt + 16'd1;
            end
            prev_hold = TX_ST_VALID && !TX_ST_READY;
            prev_head = h;
            if (TX_TLP_VALID && TX_TLP_READY) begin
                fwd     = 1'b1;
                e       = '0;
                e.data  = TX_TLP;
                e.eop   = TX_TLP_END_FLAG;
                e.empty = TX_TLP_END_FLAG && (TX_TLP_END_OFFSET < 3'd4);
                e.dwen  = TX_TLP_END_FLAG ? 8'((1 << (int'(TX_TLP_END_OFFSET) + 1)) - 1) : 8'hFF;
                if (!m_inpkt) begin
                    if (!TX_TLP_START_FLAG) begin
                        fwd   = 1'b0;
                        m_err = 1'b1;
                    end else begin
                        e.sop = 1'b1;
                        if (TX_TLP_START_OFFSET != 3'd0) m_err = 1'b1;
                    end
                end else if (TX_TLP_START_FLAG) begin
                    m_err = 1'b1;
                end
                if (fwd) begin
                    exp_q.push_back(e);
                    m_inpkt = !TX_TLP_END_FLAG;
                end
            end
            prev_rst = 1'b0;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        if (rand_rdy) TX_ST_READY = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic s, input logic e, input logic [2:0] so,
                        input logic [2:0] eo, input logic [255:0] d);
        bit ok;
        TX_TLP_VALID        = 1'b1;
        TX_TLP_START_FLAG   = s;
        TX_TLP_END_FLAG     = e;
        TX_TLP_START_OFFSET = so;
        TX_TLP_END_OFFSET   = eo;
        TX_TLP              = d;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            ok = TX_TLP_READY;
            step();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: got no accept want accept within 200 cycles");
        end
        TX_TLP_VALID = 1'b0;
    endtask

    task automatic do_reset();
        RST_IN       = 1'b1;
        TX_TLP_VALID = 1'b0;
        #1;
        chk("rst_valid", TX_ST_VALID, 0);
        chk("rst_flags", {TX_ST_SOP, TX_ST_EOP, TX_ST_EMPTY, TX_ST_DWEN}, 0);
        chk("rst_data", TX_ST_DATA, 0);
        chk("rst_ready", TX_TLP_READY, 0);
        chk("rst_count", TX_PKT_COUNT, 0);
        chk("rst_err", TX_FRAME_ERR, 0);
        step();
        step();
        RST_IN = 1'b0;
        chk("rst_ready_hold", TX_TLP_READY, 0);
        step();
        chk("rst_ready_up", TX_TLP_READY, 1);
    endtask

    typedef struct {
        logic       s, e;
        logic [2:0] so, eo;
        logic       fwd, sop, eop, empty;
        logic [7:0] dwen;
        logic       err;
        int         cnt;
    } vec_t;

    vec_t vt[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d;
        logic [255:0] hd;
        int           len;

        //         s  e  so eo  fwd sop eop emp dwen   err cnt
        vt[0]  = '{1, 1, 0, 2,  1,  1,  1,  1,  8'h07, 0,  1};
        vt[1]  = '{1, 0, 0, 0,  1,  1,  0,  0,  8'hFF, 0,  1};
        vt[2]  = '{0, 0, 0, 0,  1,  0,  0,  0,  8'hFF, 0,  1};
        vt[3]  = '{0, 1, 0, 7,  1,  0,  1,  0,  8'hFF, 0,  2};
        vt[4]  = '{1, 1, 0, 0,  1,  1,  1,  1,  8'h01, 0,  3};
        vt[5]  = '{1, 1, 0, 3,  1,  1,  1,  1,  8'h0F, 0,  4};
        vt[6]  = '{1, 1, 0, 4,  1,  1,  1,  0,  8'h1F, 0,  5};
        vt[7]  = '{0, 1, 0, 5,  0,  0,  0,  0,  8'h00, 1,  5};
        vt[8]  = '{1, 1, 0, 6,  1,  1,  1,  0,  8'h7F, 1,  6};
        vt[9]  = '{1, 1, 2, 5,  1,  1,  1,  0,  8'h3F, 1,  7};
        vt[10] = '{1, 0, 0, 1,  1,  1,  0,  0,  8'hFF, 1,  7};
        vt[11] = '{1, 1, 0, 6,  1,  0,  1,  0,  8'h7F, 1,  8};

        step();
        do_reset();

        // Directed single-beat vectors, output one cycle after acceptance.
        TX_ST_READY = 1'b1;
        for (int i = 0; i < 12; i++) begin
            d = {8{$urandom()}};
            send(vt[i].s, vt[i].e, vt[i].so, vt[i].eo, d);
            chk($sformatf("vec%0d_valid", i), TX_ST_VALID, vt[i].fwd);
            if (vt[i].fwd) begin
                chk($sformatf("vec%0d_data", i), TX_ST_DATA, d);
                chk($sformatf("vec%0d_flags", i), {TX_ST_SOP, TX_ST_EOP, TX_ST_EMPTY, TX_ST_DWEN},
                    {vt[i].sop, vt[i].eop, vt[i].empty, vt[i].dwen});
            end
            chk($sformatf("vec%0d_err", i), TX_FRAME_ERR, vt[i].err);
            step();
            chk($sformatf("vec%0d_count", i), TX_PKT_COUNT, vt[i].cnt);
        end

        // Backpressure: two beats fill the buffer, the third must wait.
        do_reset();
        TX_ST_READY = 1'b0;
        hd = {8{$urandom()}};
        send(1, 0, 0, 0, hd);
        send(0, 0, 0, 0, {8{$urandom()}});
        TX_TLP_VALID = 1'b1;
        TX_TLP_START_FLAG = 1'b0;
        TX_TLP_END_FLAG = 1'b0;
        TX_TLP = {8{$urandom()}};
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready_low", TX_TLP_READY, 0);
            chk("bp_head_data", TX_ST_DATA, hd);
            chk("bp_head_sop", TX_ST_SOP, 1);
            step();
        end
        TX_ST_READY = 1'b1;
        send(0, 0, 0, 0, TX_TLP);
        send(0, 1, 0, 7, {8{$urandom()}});
        for (int i = 0; i < 4; i++) step();
        chk("bp_count", TX_PKT_COUNT, 1);

        // Reset with two beats of an unfinished packet buffered.
        TX_ST_READY = 1'b0;
        send(1, 0, 0, 0, {8{$urandom()}});
        send(0, 0, 0, 0, {8{$urandom()}});
        chk("mid_full", TX_TLP_READY, 0);
        do_reset();
        TX_ST_READY = 1'b1;
        d = {8{$urandom()}};
        send(1, 0, 0, 0, d);
        chk("post_rst_sop", {TX_ST_VALID, TX_ST_SOP, TX_ST_DATA}, {1'b1, 1'b1, d});
        send(0, 1, 0, 1, {8{$urandom()}});
        for (int i = 0; i < 3; i++) step();
        chk("post_rst_count", TX_PKT_COUNT, 1);

        // Random back-to-back packets with 50% sink readiness.
        do_reset();
        rand_rdy = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++)
                send(b == 0, b == len - 1, 0, 3'($urandom_range(0, 7)), {8{$urandom()}});
            if ($urandom_range(0, 3) == 0) step();
        end
        rand_rdy = 1'b0;
        TX_ST_READY = 1'b1;
        for (int t = 0; t < 100 && TX_ST_VALID; t++) step();
        step();
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_count", TX_PKT_COUNT, 1000);
        chk("rand_err", TX_FRAME_ERR, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
